// File: rtl/tmds_rx_decoder.sv
// TMDS channel receiver: word alignment by control-token search, 10b->8b decode,
// and active-area x/y position counters. Two-stage pipeline from window to outputs.
module tmds_rx_decoder #(
    parameter int LOCK_RUN      = 16,
    parameter int SEARCH_WINDOW = 1024,
    parameter int H_MAX         = 2047
) (
    input  logic        clk_low,
    input  logic        reset,
    input  logic [9:0]  sym_in,
    output logic [7:0]  pixel,
    output logic        de,
    output logic [1:0]  ctrl,
    output logic        locked,
    output logic [3:0]  bit_offset,
    output logic [10:0] x,
    output logic [10:0] y
);
    localparam int RW = $clog2(LOCK_RUN + 1);
    localparam int TW = (SEARCH_WINDOW > 2) ? $clog2(SEARCH_WINDOW) : 1;

    typedef enum logic {S_SEARCH, S_LOCKED} state_t;

    state_t         state, state_n;
    logic [3:0]     off_n;
    logic [RW-1:0]  run_cnt, run_n, run_inc;
    logic [TW-1:0]  tmo_cnt, tmo_n;
    logic           tmo_hit;
    logic [9:0]     sym_prev, window, win_r;
    logic [18:0]    stream;
    logic [2:0]     tok_w, tok_r;
    logic           de_q, c1_q;

    // {hit, value}
    function automatic logic [2:0] tok_dec(input logic [9:0] w);
        case (w)
            10'b1101010100: tok_dec = 3'b100;
            10'b0010101011: tok_dec = 3'b101;
            10'b0101010100: tok_dec = 3'b110;
            10'b1010101011: tok_dec = 3'b111;
            default:        tok_dec = 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] data_dec(input logic [9:0] q);
        logic [7:0] d, p;
        d    = q[9] ? ~q[7:0] : q[7:0];
        p[0] = d[0];
        for (int i = 1; i < 8; i++)
            p[i] = q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        return p;
    endfunction

    // Top bit of the 20-bit stream is never reachable with offsets 0..9.
    assign stream = {sym_in[8:0], sym_prev};

    always_comb begin
        window = stream[9:0];
        for (int k = 1; k < 10; k++)
            if (bit_offset == 4'(k)) window = stream[k +: 10];
    end

    assign tok_w   = tok_dec(window);
    assign tok_r   = tok_dec(win_r);
    assign tmo_hit = (tmo_cnt == TW'(SEARCH_WINDOW - 1));

    always_comb begin
        state_n = state;
        off_n   = bit_offset;
        run_n   = run_cnt;
        tmo_n   = tmo_cnt;
        if (!tok_w[2])                       run_inc = '0;
        else if (run_cnt == RW'(LOCK_RUN))   run_inc = run_cnt;
        else                                 run_inc = run_cnt + 1'b1;
        case (state)
            S_SEARCH: begin
                if (run_inc == RW'(LOCK_RUN)) begin
                    state_n = S_LOCKED;
                    run_n   = '0;
                    tmo_n   = '0;
                end else if (tmo_hit) begin
                    off_n = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
                    run_n = '0;
                    tmo_n = '0;
                end else begin
                    run_n = run_inc;
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
            default: begin
                run_n = run_inc;
                if (run_inc == RW'(LOCK_RUN)) begin
                    tmo_n = '0;
                end else if (tmo_hit) begin
                    state_n = S_SEARCH;
                    run_n   = '0;
                    tmo_n   = '0;
                end else begin
                    tmo_n = tmo_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_low) begin
        if (reset) begin
            state      <= S_SEARCH;
            bit_offset <= '0;
            run_cnt    <= '0;
            tmo_cnt    <= '0;
            sym_prev   <= '0;
            win_r      <= '0;
        end else begin
            state      <= state_n;
            bit_offset <= off_n;
            run_cnt    <= run_n;
            tmo_cnt    <= tmo_n;
            sym_prev   <= sym_in;
            win_r      <= window;
        end
    end

    // Stage 2: gated by the state that was entered when win_r was captured.
    always_ff @(posedge clk_low) begin
        if (reset) begin
            pixel  <= '0;
            de     <= 1'b0;
            ctrl   <= '0;
            locked <= 1'b0;
            x      <= '0;
            y      <= '0;
            de_q   <= 1'b0;
            c1_q   <= 1'b0;
        end else begin
            locked <= (state == S_LOCKED);
            de_q   <= de;
            c1_q   <= ctrl[1];
            if (state != S_LOCKED) begin
                pixel <= '0;
                de    <= 1'b0;
                ctrl  <= '0;
                x     <= '0;
                y     <= '0;
            end else begin
                if (tok_r[2]) begin
                    pixel <= '0;
                    de    <= 1'b0;
                    ctrl  <= tok_r[1:0];
                end else begin
                    pixel <= data_dec(win_r);
                    de    <= 1'b1;
                end
                if (de) begin
                    if (x != 11'(H_MAX)) x <= x + 1'b1;
                end else if (de_q) begin
                    x <= '0;
                end
                // Frame start overrides the line increment.
                if (ctrl[1] && !c1_q)
                    y <= '0;
                else if (de_q && !de && y != 11'(H_MAX))
                    y <= y + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Directed bench for tmds_rx_decoder: lock, decode, counters, reset, loss and slip.
module tb_tmds_rx_decoder;
    logic        clk_low = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  sym_in  = '0;
    logic [9:0]  sym_s   = '0;
    logic [7:0]  pixel,  pixel_s;
    logic        de,     de_s;
    logic [1:0]  ctrl,   ctrl_s;
    logic        locked, locked_s;
    logic [3:0]  bit_offset, off_s;
    logic [10:0] x, y, x_s, y_s;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] D0 = 10'b0100000000;
    localparam logic [9:0] D1 = 10'b1011111111;
    // T0 delayed by 3 bits in the serial stream.
    localparam logic [9:0] W3 = 10'b1010100110;

    tmds_rx_decoder dut (
        .clk_low(clk_low), .reset(reset), .sym_in(sym_in),
        .pixel(pixel), .de(de), .ctrl(ctrl), .locked(locked),
        .bit_offset(bit_offset), .x(x), .y(y)
    );

    tmds_rx_decoder #(.SEARCH_WINDOW(32)) dut_s (
        .clk_low(clk_low), .reset(reset), .sym_in(sym_s),
        .pixel(pixel_s), .de(de_s), .ctrl(ctrl_s), .locked(locked_s),
        .bit_offset(off_s), .x(x_s), .y(y_s)
    );

    always #5 clk_low = ~clk_low;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive(input logic [9:0] s);
        sym_in = s;
        @(posedge clk_low);
        #1;
    endtask

    initial begin
        logic [9:0] dv [5];
        logic [7:0] dp [5];
        int xe, xbad, ymid, last, nvis, seqbad, early;
        dv = '{D0, D1, 10'b0100000011, 10'b1100001111, 10'b1000000001};
        dp = '{8'h00, 8'hFE, 8'h05, 8'h10, 8'hFC};

        repeat (3) @(posedge clk_low);
        #1;
        chk("rst_locked", locked, 0);
        chk("rst_de", de, 0);
        chk("rst_pixel", pixel, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_off", bit_offset, 0);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        reset = 1'b0;

        // Offset-0 window is the previous word, so a word shows up 3 edges later.
        for (int n = 1; n <= 20; n++) begin
            drive(T0);
            if (n == 17) chk("lock_early", locked, 0);
            if (n == 18) begin
                chk("lock", locked, 1);
                chk("lock_ctrl", ctrl, 0);
                chk("lock_de", de, 0);
                chk("lock_off", bit_offset, 0);
            end
        end

        repeat (3) drive(T1);
        for (int i = 0; i < 7; i++) begin
            drive(i < 5 ? dv[i] : T0);
            if (i >= 2) begin
                chk($sformatf("pix%0d", i - 2), pixel, dp[i-2]);
                chk("de_data", de, 1);
                chk("ctrl_hold", ctrl, 2'b01);
            end
        end
        repeat (20) drive(T0);
        chk("gap_de", de, 0);
        chk("gap_ctrl", ctrl, 0);
        chk("gap_x", x, 0);
        chk("gap_y", y, 1);

        for (int line = 1; line <= 2; line++) begin
            xe = 0; xbad = 0; ymid = -1;
            for (int n = 0; n < 660; n++) begin
                drive(n < 640 ? D0 : T0);
                if (de) begin
                    if (x != 11'(xe)) xbad++;
                    if (xe == 320) ymid = int'(y);
                    xe++;
                end
            end
            chk("x_run", xbad, 0);
            chk("x_cnt", xe, 640);
            chk("y_line", ymid, line);
        end
        chk("y_after", y, 3);

        repeat (50) drive(D0);
        chk("x_midline", x, 47);
        reset = 1'b1;
        drive(T0);
        reset = 1'b0;
        chk("rst2_locked", locked, 0);
        chk("rst2_off", bit_offset, 0);
        chk("rst2_x", x, 0);
        chk("rst2_y", y, 0);
        chk("rst2_de", de, 0);
        for (int n = 1; n <= 20; n++) begin
            drive(T0);
            if (n == 17) chk("relock_early", locked, 0);
            if (n == 18) chk("relock", locked, 1);
        end

        repeat (10) drive(D0);
        repeat (20) drive(T0);
        chk("y_short", y, 1);
        repeat (20) drive(T2);
        chk("vs_ctrl", ctrl, 2'b10);
        chk("vs_y", y, 0);

        for (int j = 1; j <= 1026; j++) begin
            drive(D1);
            if (j == 500) begin
                chk("loss_pix", pixel, 8'hFE);
                chk("loss_de", de, 1);
            end
            if (j == 1025) chk("loss_hold", locked, 1);
            if (j == 1026) begin
                chk("loss", locked, 0);
                chk("loss_de0", de, 0);
                chk("loss_pix0", pixel, 0);
                chk("loss_off", bit_offset, 0);
            end
        end

        reset = 1'b1;
        sym_s = '0;
        drive(10'd0);
        reset = 1'b0;
        sym_s = W3;
        last = 0; nvis = 1; seqbad = 0; early = 0;
        for (int n = 0; n < 400 && !locked_s; n++) begin
            drive(D0);
            if (int'(off_s) != last) begin
                if (int'(off_s) != last + 1) seqbad++;
                last = int'(off_s);
                nvis++;
            end
            if (locked_s && off_s < 4'd3) early++;
        end
        chk("slip_seq", seqbad, 0);
        chk("slip_nvis", nvis, 4);
        chk("slip_early", early, 0);
        chk("slip_lock", locked_s, 1);
        chk("slip_off", off_s, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
